mc_decode: RTL

Multicycle control unit that produces the per-cycle control strobes (NextPC, RegW, MemW, PCS, FlagW) consumed by the conditional-execution logic, plus all datapath mux selects. It sits between the instruction register and the conditional logic/datapath. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. A combinational ALU/flag decoder runs beside it.

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/mc_decode_aludec.sv | 28 ++
 rtl/mc_decode.sv | 115 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared state and encoding definitions for the multicycle control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/mc_decode_aludec.sv
// ALU operation and flag-write decoder driven by the instruction Funct field.
module aludec
    import ctrl_pkg::*;
(
    input  logic [5:0] Funct,
    input  logic       ALUOp,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
);

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        if (ALUOp) begin
            unique case (Funct[4:1])
                4'b0100: ALUControl = ALU_ADD;
                4'b0010: ALUControl = ALU_SUB;
                4'b0000: ALUControl = ALU_AND;
                4'b1100: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            // Carry/overflow only meaningful for arithmetic operations.
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
        end
    end

endmodule

// File: rtl/mc_decode.sv
// Multicycle Moore control FSM: per-state strobes, mux selects and PCS request.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW
);

    statetype_t state_q, state_d;
    logic       alu_op;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        unique case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                unique case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        unique case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: ALUSrcB = SRCB_IMM;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_RDATA;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            ALUWB: RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    aludec u_aludec (
        .Funct      (Funct),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl),
        .FlagW      (FlagW)
    );

    // A register write to R15 is a PC write and must go through condition gating.
    assign PCS    = (RegW & (Rd == 4'hF)) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule
